holiday_lights_sequencer: RTL

HOLIDAY_LIGHTS_SEQUENCER -- requirements
Module: holiday_lights_sequencer

---
 rtl/holiday_lights_pkg.sv | 37 +++
 rtl/holiday_lights_sequencer_btn_debounce.sv | 53 +++++
 rtl/holiday_lights_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/holiday_lights_pkg.sv
`default_nettype none
// ============================================================================
// holiday_lights_pkg -- state encodings, datapath widths and timing defaults
// Rev 1.0
// ============================================================================
package holiday_lights_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    localparam int POS_W   = 4;
    localparam int WIDTH_W = 3;

    localparam int CNT_MAX_HW  = 100_000_000;
    localparam int DEB_MAX_HW  = 1_000_000;
    localparam int CNT_MAX_SIM = 4;
    localparam int DEB_MAX_SIM = 2;

`ifdef SIMULATION
    localparam int CNT_MAX_DEF = CNT_MAX_SIM;
    localparam int DEB_MAX_DEF = DEB_MAX_SIM;
`else
    localparam int CNT_MAX_DEF = CNT_MAX_HW;
    localparam int DEB_MAX_DEF = DEB_MAX_HW;
`endif

    // Highest head position before a lit segment of this width touches LED 15.
    function automatic logic [POS_W-1:0] bounce_limit(input logic [WIDTH_W-1:0] w);
        return 4'd15 - {1'b0, w};
    endfunction

endpackage
`default_nettype wire

// File: rtl/holiday_lights_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce -- 2-flop synchroniser, stable-count debouncer, press pulse
// Rev 1.0
// ============================================================================
module btn_debounce
    import holiday_lights_pkg::*;
#(
    parameter int DEB_MAX = DEB_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    output logic press_o
);

    localparam int CW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_MAX - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive synchronised samples that disagree with stable_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                stable_q <= sync2_q;
                press_q  <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/holiday_lights_sequencer.sv
`default_nettype none
// ============================================================================
// holiday_lights_sequencer -- button-driven running-light position sequencer
// Rev 1.0
// ============================================================================
module holiday_lights_sequencer
    import holiday_lights_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int DEB_MAX = DEB_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button_i,
    input  logic [WIDTH_W-1:0] switch_i,
    input  logic               auto_en_i,
    input  logic               bounce_en_i,
    output logic               step_o,
    output logic [POS_W-1:0]   pos_o,
    output logic [WIDTH_W-1:0] width_o,
    output logic               dir_o,
    output logic [1:0]         state_o
);

    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic               dir_q, dir_d;
    logic               step_q, step_d;

    logic               press;
    logic               lap;
    logic [POS_W-1:0]   pos_adv;
    logic               dir_adv;
    logic [WIDTH_W-1:0] width_adv;

    btn_debounce #(
        .DEB_MAX (DEB_MAX)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .button_i (button_i),
        .press_o  (press)
    );

    // Candidate position/direction/width if this cycle turns out to be a step.
    // Leaving bounce mode while heading down simply takes the wrap branch,
    // which clears dir and moves up.
    always_comb begin
        lap     = 1'b0;
        pos_adv = pos_q + 4'd1;
        dir_adv = 1'b0;
        if (bounce_en_i) begin
            if (!dir_q) begin
                if (pos_q >= bounce_limit(width_q)) begin
                    dir_adv = 1'b1;
                    pos_adv = pos_q - 4'd1;
                end
            end else if (pos_q == '0) begin
                pos_adv = 4'd1;
                lap     = 1'b1;
            end else begin
                dir_adv = 1'b1;
                pos_adv = pos_q - 4'd1;
            end
        end else begin
            lap = (pos_q == 4'd15);
        end
        width_adv = auto_en_i ? (width_q + {2'b00, lap}) : switch_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        width_d = width_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                width_d = switch_i;
                if (press) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    pos_d   = pos_adv;
                    dir_d   = dir_adv;
                    width_d = width_adv;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (press) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (press) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered step lines up with the cycle in which cnt_q shows CNT_LAST.
        step_d = (state_d == ST_RUN) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            width_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            width_q <= width_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign step_o  = step_q;
    assign pos_o   = pos_q;
    assign width_o = width_q;
    assign dir_o   = dir_q;
    assign state_o = state_q;

endmodule
`default_nettype wire
